lsu_datamem: RTL and testbench

Parametrised load/store unit with integrated byte-addressable data memory. It replaces the single-cycle, always-ready data memory in the core datapath. It adds:
- a valid/ready request handshake and a one-cycle response pulse;
- configurable read latency;
- RV32 sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with sign or zero extension;
- misalignment and range error reporting.

The core stalls on `busy` while an access is in flight.

---
 rtl/lsu_datamem_if.sv | 25 ++
 rtl/lsu_datamem.sv | 151 +++++++++++++++
 tb/tb_lsu_datamem.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_datamem_if.sv
// rtl/lsu_datamem_if.sv - request/response bundle between the core and lsu_datamem
interface lsu_datamem_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic            busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/lsu_datamem.sv
// rtl/lsu_datamem.sv - load/store unit with byte-addressable data memory
module lsu_datamem #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LATENCY  = 1
) (
    input  logic         clk,
    input  logic         rst,
    lsu_datamem_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [XLEN-1:0] pend, pend_nxt;
    logic [XLEN-1:0] rdata_q, rdata_nxt;
    logic            err_q, err_nxt;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            misal, bad_f3, out_of_range, dec_err;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] word, ld_val, wr_data;
    logic [3:0]      be;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [2:0]      f3;

    assign f3           = bus.req_funct3;
    assign accept       = bus.req_valid && bus.req_ready;
    assign idx          = bus.req_addr[AW+1:2];
    assign word         = mem[idx];
    assign out_of_range = |bus.req_addr[XLEN-1:AW+2];
    assign dec_err      = misal || bad_f3 || out_of_range;

    // funct3[1:0] gives the size; funct3[2] is only legal as the unsigned flag of LBU/LHU
    always_comb begin
        misal  = 1'b0;
        bad_f3 = 1'b0;
        case (f3[1:0])
            2'b01:   misal  = bus.req_addr[0];
            2'b10:   misal  = |bus.req_addr[1:0];
            2'b11:   bad_f3 = 1'b1;
            default: misal  = 1'b0;
        endcase
        if (f3[2] && (bus.req_we || f3[1])) begin
            bad_f3 = 1'b1;
        end
    end

    assign ld_byte = word[8*bus.req_addr[1:0] +: 8];
    assign ld_half = bus.req_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_val  = word;
        wr_data = bus.req_wdata;
        be      = 4'b1111;
        case (f3[1:0])
            2'b00: begin
                ld_val  = {{(XLEN-8){ld_byte[7] & ~f3[2]}}, ld_byte};
                wr_data = {4{bus.req_wdata[7:0]}};
                be      = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                ld_val  = {{(XLEN-16){ld_half[15] & ~f3[2]}}, ld_half};
                wr_data = {2{bus.req_wdata[15:0]}};
                be      = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                ld_val  = word;
                wr_data = bus.req_wdata;
                be      = 4'b1111;
            end
        endcase
    end

    // Contents survive rst; a store coinciding with rst is dropped
    always_ff @(posedge clk) begin
        if (!rst && accept && bus.req_we && !dec_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        case (state)
            WAIT: begin
                if (cnt == 3'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 3'd0;
                    rdata_nxt = pend;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (dec_err) begin
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                    end else if (bus.req_we) begin
                        state_nxt = RESP;
                    end else if (RD_LATENCY == 1) begin
                        state_nxt = RESP;
                        rdata_nxt = ld_val;
                    end else begin
                        // Data is captured now; memory cannot change while WAIT blocks requests
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                        pend_nxt  = ld_val;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            pend    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.req_ready = (state != WAIT);
    assign bus.busy      = (state == WAIT);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_lsu_datamem.sv
// tb/tb_lsu_datamem.sv - randomized self-checking bench for lsu_datamem at latencies 1, 3 and 4
module tb_lsu_datamem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    int          sel = 0;

    logic        o_ready, o_rsp_valid, o_err, o_busy;
    logic [31:0] o_rdata;

    int errors = 0;
    int checks = 0;
    int rdl [3] = '{1, 3, 4};

    logic [7:0] mm [3][1024];

    lsu_datamem_if #(.XLEN(32)) if1 ();
    lsu_datamem_if #(.XLEN(32)) if3 ();
    lsu_datamem_if #(.XLEN(32)) if4 ();

    lsu_datamem #(.XLEN(32), .DEPTH_WORDS(256), .RD_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    lsu_datamem #(.XLEN(32), .DEPTH_WORDS(256), .RD_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    lsu_datamem #(.XLEN(32), .DEPTH_WORDS(256), .RD_LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    assign if1.req_valid = req_valid && (sel == 0);
    assign if3.req_valid = req_valid && (sel == 1);
    assign if4.req_valid = req_valid && (sel == 2);
    assign if1.req_we = req_we;  assign if3.req_we = req_we;  assign if4.req_we = req_we;
    assign if1.req_funct3 = req_funct3;  assign if3.req_funct3 = req_funct3;  assign if4.req_funct3 = req_funct3;
    assign if1.req_addr = req_addr;  assign if3.req_addr = req_addr;  assign if4.req_addr = req_addr;
    assign if1.req_wdata = req_wdata;  assign if3.req_wdata = req_wdata;  assign if4.req_wdata = req_wdata;

    always_comb begin
        o_ready = if1.req_ready; o_rsp_valid = if1.rsp_valid; o_rdata = if1.rsp_rdata;
        o_err = if1.rsp_err; o_busy = if1.busy;
        if (sel == 1) begin
            o_ready = if3.req_ready; o_rsp_valid = if3.rsp_valid; o_rdata = if3.rsp_rdata;
            o_err = if3.rsp_err; o_busy = if3.busy;
        end else if (sel == 2) begin
            o_ready = if4.req_ready; o_rsp_valid = if4.rsp_valid; o_rdata = if4.rsp_rdata;
            o_err = if4.rsp_err; o_busy = if4.busy;
        end
    end

    always #5 clk = ~clk;

    // Reference: byte-array memory, RV32 size/sign rules applied arithmetically
    task automatic model(input int s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        logic [63:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        er = 1'b0;
        rd = 32'd0;
        if (size == 0) er = 1'b1;
        if (we && f3 > 3'd2) er = 1'b1;
        if (!we && (f3 == 3'd6 || f3 == 3'd7)) er = 1'b1;
        if (size != 0 && (a % size) != 0) er = 1'b1;
        if ((a / 4) >= 256) er = 1'b1;
        if (er) return;
        if (we) begin
            for (int b = 0; b < size; b++) mm[s][a + b] = wd[8*b +: 8];
        end else begin
            v = 64'd0;
            for (int b = 0; b < size; b++) v = v + (64'(mm[s][a + b]) << (8 * b));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
            rd = v[31:0];
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int bcyc,
                          output logic rdy0);
        rdy0 = o_ready;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        lat = 0; bcyc = 0; rd = 32'd0; er = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                lat = i; rd = o_rdata; er = o_err;
                break;
            end
            if (o_busy) bcyc++;
        end
    endtask

    task automatic test_reset;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (o_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_rdata !== 32'd0 || o_err !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: ready=%b rsp_valid=%b busy=%b rdata=%h err=%b, required 1 0 0 0 0",
                         s, o_ready, o_rsp_valid, o_busy, o_rdata, o_err);
            end
        end
        sel = 0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] rd, erd; logic er, eer, r0; int lat, bc;
        sel = 0;
        model(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, erd, eer);
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat, bc, r0);
        checks++;
        if (er !== 1'b0 || rd !== 32'd0 || lat != 1) begin
            errors++;
            $display("FAIL sw_basic: err=%b rdata=%h lat=%0d, required 0 00000000 1", er, rd, lat);
        end
        model(0, 1'b0, 3'd2, 32'h10, 32'h0, erd, eer);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, r0);
        checks++;
        if (r0 !== 1'b1 || er !== 1'b0 || rd !== 32'hDEADBEEF || rd !== erd || lat != 1) begin
            errors++;
            $display("FAIL lw_after_sw: ready=%b err=%b rdata=%h lat=%0d, required 1 0 deadbeef 1", r0, er, rd, lat);
        end
        @(negedge clk);
        checks++;
        if (o_rsp_valid !== 1'b0 || o_rdata !== 32'd0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: rsp_valid=%b rdata=%h err=%b, required 0 0 0", o_rsp_valid, o_rdata, o_err);
        end
    endtask

    task automatic test_subword_loads;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] as  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        logic [31:0] rd, erd; logic er, eer, r0; int lat, bc;
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            model(0, 1'b0, f3s[i], as[i], 32'h0, erd, eer);
            do_req(1'b0, f3s[i], as[i], 32'h0, rd, er, lat, bc, r0);
            checks++;
            if (rd !== exp[i] || rd !== erd || er !== 1'b0 || lat != 1) begin
                errors++;
                $display("FAIL subload[%0d]: rdata=%h err=%b lat=%0d, required %h 0 1", i, rd, er, lat, exp[i]);
            end
        end
    endtask

    task automatic test_subword_stores;
        logic [31:0] rd, erd; logic er, eer, r0; int lat, bc;
        sel = 0;
        model(0, 1'b1, 3'd0, 32'h11, 32'hAAAAAA55, erd, eer);
        do_req(1'b1, 3'd0, 32'h11, 32'hAAAAAA55, rd, er, lat, bc, r0);
        model(0, 1'b1, 3'd1, 32'h16, 32'hBBBB1234, erd, eer);
        do_req(1'b1, 3'd1, 32'h16, 32'hBBBB1234, rd, er, lat, bc, r0);
        model(0, 1'b0, 3'd2, 32'h10, 32'h0, erd, eer);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, r0);
        checks++;
        if (rd !== 32'hDEAD55EF || rd !== erd) begin
            errors++;
            $display("FAIL sb_merge: rdata=%h, required deadbeef-merged dead55ef", rd);
        end
        do_req(1'b0, 3'd4, 32'h16, 32'h0, rd, er, lat, bc, r0);
        checks++;
        if (rd !== 32'h34) begin
            errors++;
            $display("FAIL sh_lane16: rdata=%h, required 00000034", rd);
        end
        do_req(1'b0, 3'd4, 32'h17, 32'h0, rd, er, lat, bc, r0);
        checks++;
        if (rd !== 32'h12) begin
            errors++;
            $display("FAIL sh_lane17: rdata=%h, required 00000012", rd);
        end
    endtask

    task automatic test_errors;
        logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
        logic [31:0] as  [4] = '{32'h11, 32'h03, 32'd1024, 32'h10};
        logic [31:0] rd, erd; logic er, eer, r0; int lat, bc;
        sel = 0;
        model(0, 1'b1, 3'd2, 32'h0, 32'h0BADF00D, erd, eer);
        do_req(1'b1, 3'd2, 32'h0, 32'h0BADF00D, rd, er, lat, bc, r0);
        for (int i = 0; i < 4; i++) begin
            model(0, wes[i], f3s[i], as[i], 32'hFFFFFFFF, erd, eer);
            do_req(wes[i], f3s[i], as[i], 32'hFFFFFFFF, rd, er, lat, bc, r0);
            checks++;
            if (er !== 1'b1 || eer !== 1'b1 || rd !== 32'd0 || lat != 1) begin
                errors++;
                $display("FAIL err_case[%0d]: err=%b rdata=%h lat=%0d, required 1 00000000 1", i, er, rd, lat);
            end
        end
        for (int w = 0; w < 2; w++) begin
            model(0, 1'b0, 3'd2, 32'(w * 16), 32'h0, erd, eer);
            do_req(1'b0, 3'd2, 32'(w * 16), 32'h0, rd, er, lat, bc, r0);
            checks++;
            if (rd !== erd || er !== 1'b0) begin
                errors++;
                $display("FAIL err_nowrite[%0d]: rdata=%h err=%b, required %h 0", w, rd, er, erd);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, erd; logic er, eer, r0; int lat, bc;
        sel = 1;
        model(1, 1'b1, 3'd2, 32'h40, 32'hCAFE0123, erd, eer);
        do_req(1'b1, 3'd2, 32'h40, 32'hCAFE0123, rd, er, lat, bc, r0);
        checks++;
        if (lat != 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL l3_store: lat=%0d err=%b, required 1 0", lat, er);
        end
        model(1, 1'b0, 3'd2, 32'h40, 32'h0, erd, eer);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat, bc, r0);
        checks++;
        if (r0 !== 1'b1 || lat != 3 || bc != 2 || rd !== erd) begin
            errors++;
            $display("FAIL l3_load: ready=%b lat=%0d busy_cycles=%0d rdata=%h, required 1 3 2 %h", r0, lat, bc, rd, erd);
        end
        model(1, 1'b0, 3'd1, 32'h42, 32'h0, erd, eer);
        do_req(1'b0, 3'd1, 32'h42, 32'h0, rd, er, lat, bc, r0);
        checks++;
        if (r0 !== 1'b1 || lat != 3 || rd !== erd || rd !== 32'hFFFFCAFE) begin
            errors++;
            $display("FAIL l3_b2b: ready=%b lat=%0d rdata=%h, required 1 3 ffffcafe", r0, lat, rd);
        end
    endtask

    task automatic test_reset_inflight;
        logic [31:0] rd, erd; logic er, eer, r0; int lat, bc; int seen;
        sel = 2;
        model(2, 1'b1, 3'd0, 32'h20, 32'h000000A5, erd, eer);
        do_req(1'b1, 3'd0, 32'h20, 32'h000000A5, rd, er, lat, bc, r0);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL l4_rst_ready: ready=%b busy=%b, required 1 0", o_ready, o_busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_rsp_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL l4_rst_drop: rsp_valid cycles=%0d, required 0", seen);
        end
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'h3C;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_sb_rsp: rsp_valid=%b, required 0", o_rsp_valid);
        end
        model(2, 1'b0, 3'd0, 32'h20, 32'h0, erd, eer);
        do_req(1'b0, 3'd0, 32'h20, 32'h0, rd, er, lat, bc, r0);
        checks++;
        if (rd !== 32'hFFFFFFA5 || rd !== erd || lat != 4) begin
            errors++;
            $display("FAIL rst_sb_nowrite: rdata=%h lat=%0d, required ffffffa5 4", rd, lat);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, wd; logic er, eer, r0, we; logic [2:0] f3; int lat, bc, elat;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                model(s, 1'b1, 3'd2, 32'(w * 4), wd, erd, eer);
                do_req(1'b1, 3'd2, 32'(w * 4), wd, rd, er, lat, bc, r0);
            end
            for (int n = 0; n < 40; n++) begin
                we = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                a  = ($urandom_range(0, 7) == 0) ? 32'(1024 + $urandom_range(0, 63)) : 32'($urandom_range(0, 63));
                wd = $urandom;
                model(s, we, f3, a, wd, erd, eer);
                elat = (eer || we) ? 1 : rdl[s];
                do_req(we, f3, a, wd, rd, er, lat, bc, r0);
                checks++;
                if (rd !== erd || er !== eer || lat != elat) begin
                    errors++;
                    $display("FAIL random[%0d.%0d] we=%b f3=%0d a=%h: rdata=%h err=%b lat=%0d, required %h %b %0d",
                             s, n, we, f3, a, rd, er, lat, erd, eer, elat);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_subword_loads;
        test_subword_stores;
        test_errors;
        test_back_to_back;
        test_reset_inflight;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
